// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port between NUM_REQ
//   producers. A winner gets a burst of up to MAX_BURST words. The arbiter
//   never writes while the FIFO is full. Each burst is followed by one
//   arbitration cycle in IDLE.
//
// Ports
//   clk       write-domain clock; all state changes on the rising edge
//   reset     asynchronous, active-low reset
//   req       per-producer request; the producer's word is valid while high
//   req_data  producer words; producer i occupies [i*WIDTH +: WIDTH]
//   full      FIFO full flag
//   ack       per-producer accept; a word moves at an edge with req[i] & ack[i]
//   write     FIFO write strobe
//   fifo_data word presented to the FIFO data input
//   owner     index of the current (or most recent) grant holder
//   busy      high while a burst grant is active
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic                       full,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       write,
  output logic [WIDTH-1:0]           fifo_data,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]   owner_reg, owner_next;
  logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;

  logic [WIDTH-1:0]   data_arr [NUM_REQ];
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   owner_inc;
  logic               xfer;

  // Unpack the flat producer data bus into one word per producer.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Circular priority search starting at rr_ptr. The loop runs from the
  // farthest candidate down to rr_ptr itself, so the last match written is
  // the nearest requester at or above rr_ptr.
  always_comb begin
    int idx;
    idx  = 0;
    pick = rr_ptr_reg;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[PTR_W'(idx)]) pick = PTR_W'(idx);
    end
  end

  assign owner_inc = (owner_reg == PTR_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

  // Zero-cycle accept: the FIFO and the producer both see the transfer on
  // the same edge, so full drops write/ack within the same cycle.
  assign xfer = (state_reg == BURST) && req[owner_reg] && !full;

  always_comb begin
    ack = '0;
    if (xfer) ack[owner_reg] = 1'b1;
  end

  assign write     = xfer;
  assign fifo_data = xfer ? data_arr[owner_reg] : '0;
  assign busy      = (state_reg == BURST);
  assign owner     = owner_reg;

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          owner_next     = pick;
          burst_cnt_next = '0;
          state_next     = BURST;
        end
      end
      BURST: begin
        if (!req[owner_reg]) begin
          // Producer released early: give up the grant, no write this cycle.
          state_next  = IDLE;
          rr_ptr_next = owner_inc;
        end else if (!full) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
          if (burst_cnt_next == CNT_W'(MAX_BURST)) begin
            state_next  = IDLE;
            rr_ptr_next = owner_inc;
          end
        end
        // req high with full high: stall with the count held.
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=4, MAX_BURST=4).
// A behavioural grant model predicts write/ack/fifo_data/owner/busy every
// cycle. Directed steps cover the listed scenarios, and a randomized phase
// follows them.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           full;
  logic [N-1:0]   ack;
  logic           write;
  logic [W-1:0]   fifo_data;
  logic [1:0]     owner;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Reference model: grant held or not, holder, words moved in this grant,
  // and the index where the next search starts.
  bit m_active;
  int m_holder;
  int m_done;
  int m_next;

  logic       last_write;
  logic       last_busy;
  int         last_owner;
  logic [3:0] last_data;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(rst_n), .req(req), .req_data(req_data), .full(full),
    .ack(ack), .write(write), .fifo_data(fifo_data), .owner(owner), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_holder = 0;
    m_done   = 0;
    m_next   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b1111;
    full  = 1'b0;
    #1;
    chk("rst_write", write, 0);
    chk("rst_ack", ack, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    model_reset();
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive, compare with the model, then advance the model.
  task automatic cycle(input logic [3:0] r, input logic [15:0] d, input logic f);
    logic       e_wr;
    logic [3:0] e_ack;
    logic [3:0] e_data;
    @(negedge clk);
    req      = r;
    req_data = d;
    full     = f;
    #1;
    e_wr   = m_active && r[m_holder] && !f;
    e_ack  = e_wr ? 4'(1 << m_holder) : 4'b0;
    e_data = e_wr ? d[m_holder*4 +: 4] : 4'b0;
    chk("write", write, e_wr);
    chk("ack", ack, e_ack);
    chk("fifo_data", fifo_data, e_data);
    chk("owner", owner, m_holder);
    chk("busy", busy, m_active);
    last_write = write;
    last_busy  = busy;
    last_owner = int'(owner);
    last_data  = fifo_data;
    if (write) $display("WR owner=%0d data=%h ack=%b", owner, fifo_data, ack);
    @(posedge clk);
    if (!m_active) begin
      if (r != 4'b0) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_next + k) % N;
          if (r[i]) begin
            m_holder = i;
            break;
          end
        end
        m_active = 1'b1;
        m_done   = 0;
      end
    end else if (!r[m_holder]) begin
      m_active = 1'b0;
      m_next   = (m_holder + 1) % N;
    end else if (!f) begin
      m_done++;
      if (m_done == MB) begin
        m_active = 1'b0;
        m_next   = (m_holder + 1) % N;
      end
    end
  endtask

  initial begin
    logic [3:0]  words [5];
    logic [3:0]  r;
    logic [6:0]  pat;
    int          wi;
    int          nw;

    rst_n = 1'b0;
    req = '0; req_data = '0; full = 1'b0;
    model_reset();

    // Reset then first grant to producer 0.
    do_reset();
    cycle(4'b1111, 16'h4321, 1'b0);
    chk("first_idle_busy", last_busy, 0);
    cycle(4'b1111, 16'h4321, 1'b0);
    chk("first_owner", last_owner, 0);
    chk("first_write", last_write, 1);

    // Single producer burst: A..D, one IDLE cycle, then E.
    do_reset();
    words = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    wi = 0;
    pat = '0;
    for (int c = 0; c < 7; c++) begin
      cycle(4'b0100, 16'(words[wi]) << 8, 1'b0);
      pat[c] = last_write;
      if (last_write) begin
        chk("sp_data", last_data, words[wi]);
        if (wi < 4) wi++;
      end
    end
    chk("sp_pattern", pat, 7'b1011110);

    // Round-robin with everyone requesting: 20 writes in 25 cycles.
    do_reset();
    nw = 0;
    for (int c = 0; c < 25; c++) begin
      cycle(4'b1111, 16'($urandom), 1'b0);
      if (last_write) begin
        if (nw % 4 == 0) chk("rr_owner", last_owner, (nw / 4) % 4);
        nw++;
      end
    end
    chk("rr_writes", nw, 20);

    // Full stall mid-burst on producer 1.
    do_reset();
    cycle(4'b0010, 16'h00A0, 1'b0);
    cycle(4'b0010, 16'h00B0, 1'b0);
    cycle(4'b0010, 16'h00C0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      cycle(4'b0010, 16'h00D0, 1'b1);
      chk("stall_write", last_write, 0);
      chk("stall_busy", last_busy, 1);
    end
    cycle(4'b0010, 16'h00D0, 1'b0);
    chk("post_stall_w1", last_write, 1);
    cycle(4'b0010, 16'h00E0, 1'b0);
    chk("post_stall_w2", last_write, 1);
    cycle(4'b0010, 16'h00F0, 1'b0);
    chk("post_stall_idle", last_busy, 0);

    // Early release by producer 3; rr_ptr wraps so producer 0 wins.
    do_reset();
    cycle(4'b1000, 16'h5000, 1'b0);
    cycle(4'b1000, 16'h5000, 1'b0);
    chk("er_owner3", last_owner, 3);
    cycle(4'b0001, 16'h0006, 1'b0);
    chk("er_release_nowrite", last_write, 0);
    cycle(4'b0011, 16'h0076, 1'b0);
    chk("er_idle", last_busy, 0);
    cycle(4'b0011, 16'h0076, 1'b0);
    chk("er_owner0", last_owner, 0);
    chk("er_write", last_write, 1);

    // Asynchronous reset in the middle of a write cycle.
    do_reset();
    cycle(4'b1111, 16'h1234, 1'b0);
    cycle(4'b1111, 16'h1234, 1'b0);
    @(negedge clk);
    req = 4'b1111; full = 1'b0;
    #1;
    chk("pre_rst_write", write, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_write", write, 0);
    chk("arst_ack", ack, 0);
    chk("arst_data", fifo_data, 0);
    chk("arst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    cycle(4'b1010, 16'h9876, 1'b0);
    cycle(4'b1010, 16'h9876, 1'b0);
    chk("arst_owner1", last_owner, 1);
    chk("arst_write1", last_write, 1);

    // Randomized traffic against the model.
    do_reset();
    r = 4'($urandom);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      cycle(r, 16'($urandom), $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one FIFO write interface between NUM_REQ producers.
- Grants one producer at a time, in bursts of up to MAX_BURST words, and never writes while the FIFO reports full.
- Sits directly in front of the FIFO write side, in the FIFO's write clock domain.

Parameters:
NUM_REQ, 4, number of requesting producers (2..8)
WIDTH, 4, data word width; matches FIFO data width
MAX_BURST, 4, max consecutive words per grant (>=1)

Ports:
clk  input  1  write-domain clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-producer request; a word is valid while high
req_data  input  NUM_REQ*WIDTH  producer words; producer i at bits [i*WIDTH +: WIDTH]
full  input  1  FIFO full flag
ack  output  NUM_REQ  per-producer accept; a transfer occurs at an edge where req[i] & ack[i]
write  output  1  FIFO write strobe
fifo_data  output  WIDTH  word to FIFO data input
owner  output  clog2(NUM_REQ)  index of current grant holder
busy  output  1  high while in BURST

Behaviour:
- Reset (async, reset=0): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0. Combinationally, write=0, ack=0, fifo_data=0 and busy=0 immediately, without waiting for a clock edge.
- States: IDLE, BURST. busy = (state==BURST).
- IDLE:
  - If req!=0 at the edge, pick the first requester with req high, searching upward circularly from rr_ptr.
  - Load owner with that index, clear burst_cnt, go to BURST.
  - If req==0, stay in IDLE.
  - IDLE always lasts at least one cycle: one arbitration cycle between bursts.
- BURST, transfer condition xfer = req[owner] & !full:
  - ack[owner]=xfer; all other ack bits are 0.
  - write=xfer.
  - fifo_data = req_data slice of owner when xfer=1, else 0.
  - All three outputs are combinational from state, owner, req and full. Zero-cycle accept; the FIFO captures on the same edge.
- BURST, transitions:
  - At an edge with xfer=1: burst_cnt+1. If the new count equals MAX_BURST, go to IDLE.
  - At an edge where req[owner]=0: go to IDLE, with no write that cycle.
  - At an edge where req[owner]=1 and full=1: stay in BURST, no transfer, burst_cnt held. There is no timeout; the grant stalls until full clears.
- Leaving BURST: rr_ptr <= owner+1, wrapping modulo NUM_REQ. The same producer cannot win again while any other producer is requesting.
- Fairness: with all producers requesting continuously, grant order is 0,1,2,...,NUM_REQ-1,0,...
- Worst-case wait from req rise to first ack is (NUM_REQ-1)*(MAX_BURST+1)+1 cycles, excluding full stalls.
- Requests from non-owners are ignored until the next IDLE. Deasserting a request before it is granted loses nothing.
- burst_cnt width is clog2(MAX_BURST+1). It never exceeds MAX_BURST.
- full rising mid-burst: write and ack drop in the same cycle, purely combinationally.
- Reset mid-burst: the partially written burst is abandoned, and the next grant goes to the lowest-indexed requester.
- owner holds its last value in IDLE.

Test Plan:
- Reset then idle: reset=0 with req=4'b1111 → write=0, ack=0, fifo_data=0, busy=0. After reset=1, the first grant goes to owner=0.
- Single producer burst: req=4'b0100 held with data A,B,C,D,E, full=0 → IDLE for 1 cycle. Then 4 consecutive writes of A..D with ack[2]=1, then 1 IDLE cycle, then E is written.
- Round-robin: req=4'b1111 held, full=0, MAX_BURST=4 → owner sequence 0,1,2,3,0. Each burst is 4 writes separated by 1 IDLE cycle; 20 writes in 25 cycles.
- Full stall: owner=1 mid-burst after 2 writes, full=1 for 3 cycles → write=0, ack=0 for those 3 cycles, busy=1. After full=0, exactly 2 more writes, then IDLE.
- Early release: owner=3, req[3] drops after 1 write while req[0]=1 → IDLE for one cycle, then owner=0. rr_ptr wraps, so 0 wins over a later-rising req[1].
- Async reset mid-burst: reset=0 between clock edges during a write → write and ack go to 0 before the next edge. After release, with req=4'b1010, owner=1.
